// File: rtl/nrzi_unstuff_rx_if.sv
// Line-side inputs and decoded-data outputs of the NRZI receiver.
// The master drives the bus samples; the slave is the receiver.
interface nrzi_unstuff_rx_if;
  logic dp;
  logic dm;
  logic recving;
  logic outb;
  logic outb_vld;
  logic sending;
  logic eop;
  logic err;

  modport master (
    output dp, dm, recving,
    input  outb, outb_vld, sending, eop, err
  );

  modport slave (
    input  dp, dm, recving,
    output outb, outb_vld, sending, eop, err
  );
endinterface

// File: rtl/nrzi_unstuff_rx.sv
// NRZI decoder with SYNC detection, bit unstuffing and EOP/error detection.
// Every output is registered: a line sample's effect shows one cycle later.
module nrzi_unstuff_rx (
  input logic             clk,
  input logic             rst,
  nrzi_unstuff_rx_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSync, StData, StEopWait} state_e;

  state_e      state_q, state_d;
  logic        prev_k_q, prev_k_d;  // last J/K line state, 1 = K
  logic [2:0]  ones_q, ones_d;
  logic [7:0]  hist_q, hist_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        se0_seen_q, se0_seen_d;
  logic        outb_q, outb_d;
  logic        vld_q, vld_d;
  logic        sending_q, sending_d;
  logic        eop_q, eop_d;
  logic        err_q, err_d;

  logic is_j, is_k, is_se0, is_jk, dec;
  logic [7:0] hist_sh;

  assign is_j    = bus.dp & ~bus.dm;
  assign is_k    = ~bus.dp & bus.dm;
  assign is_se0  = ~bus.dp & ~bus.dm;
  assign is_jk   = is_j | is_k;
  assign dec     = (is_k == prev_k_q);
  // First arrival ends in bit 0 after eight shifts; SYNC = seven 0s then a 1.
  assign hist_sh = {dec, hist_q[7:1]};

  always_comb begin
    state_d    = state_q;
    prev_k_d   = is_jk ? is_k : prev_k_q;
    ones_d     = ones_q;
    hist_d     = hist_q;
    cnt_d      = cnt_q;
    se0_seen_d = se0_seen_q;
    outb_d     = 1'b0;
    vld_d      = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;

    if (!bus.recving) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_k) begin
            state_d = StSync;
            hist_d  = {dec, 7'b0};
            cnt_d   = 4'd1;
          end
        end
        StSync: begin
          if (is_jk) begin
            hist_d = hist_sh;
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (hist_sh == 8'h80) begin
                state_d = StData;
                ones_d  = 3'd1;
              end else begin
                state_d = StIdle;
              end
            end
          end else begin
            state_d = StIdle;
          end
        end
        StData: begin
          if (is_jk) begin
            if (ones_q == 3'd6) begin
              // Stuffed slot: a 0 is dropped, a 1 is a stuffing violation.
              if (dec) begin
                err_d   = 1'b1;
                state_d = StIdle;
              end else begin
                ones_d = 3'd0;
              end
            end else begin
              outb_d = dec;
              vld_d  = 1'b1;
              ones_d = dec ? ones_q + 3'd1 : 3'd0;
            end
          end else if (is_se0) begin
            state_d    = StEopWait;
            se0_seen_d = 1'b0;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StEopWait: begin
          if (!se0_seen_q && is_se0) begin
            se0_seen_d = 1'b1;
          end else if (se0_seen_q && is_j) begin
            eop_d   = 1'b1;
            state_d = StIdle;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    sending_d = (state_d == StData) || (state_d == StEopWait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      prev_k_q   <= 1'b0;
      ones_q     <= 3'd0;
      hist_q     <= 8'd0;
      cnt_q      <= 4'd0;
      se0_seen_q <= 1'b0;
      outb_q     <= 1'b0;
      vld_q      <= 1'b0;
      sending_q  <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_k_q   <= prev_k_d;
      ones_q     <= ones_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      se0_seen_q <= se0_seen_d;
      outb_q     <= outb_d;
      vld_q      <= vld_d;
      sending_q  <= sending_d;
      eop_q      <= eop_d;
      err_q      <= err_d;
    end
  end

  assign bus.outb     = outb_q;
  assign bus.outb_vld = vld_q;
  assign bus.sending  = sending_q;
  assign bus.eop      = eop_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_nrzi_unstuff_rx.sv
// Directed scenarios for nrzi_unstuff_rx, checked every cycle against a packet-level
// model plus hand-computed per-scenario bit strings and pulse counts.
module tb_nrzi_unstuff_rx;

  logic clk;
  logic rst;
  nrzi_unstuff_rx_if bus ();

  nrzi_unstuff_rx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: mode 0 idle, 1 hunting SYNC, 2 payload, 3 want 2nd SE0, 4 want J.
  int  mode = 0;
  bit  prev_k = 1'b0;
  bit  win[$];
  int  run = 0;
  bit  e_outb, e_vld, e_send, e_eop, e_err;

  function automatic bit sync_ok();
    for (int i = 0; i < 7; i++) if (win[i]) return 1'b0;
    return win[7];
  endfunction

  always @(posedge clk) begin
    bit j, k, s0, d;
    j  = bus.dp & ~bus.dm;
    k  = ~bus.dp & bus.dm;
    s0 = ~bus.dp & ~bus.dm;
    d  = (k == prev_k);
    e_outb = 1'b0; e_vld = 1'b0; e_eop = 1'b0; e_err = 1'b0;
    if (rst) begin
      mode = 0; prev_k = 1'b0; run = 0; win.delete();
    end else begin
      if (!bus.recving) mode = 0;
      else case (mode)
        0: if (k) begin win.delete(); win.push_back(d); mode = 1; end
        1: if (j || k) begin
             win.push_back(d);
             if (win.size() == 8) begin mode = sync_ok() ? 2 : 0; run = 1; end
           end else mode = 0;
        2: if (j || k) begin
             if (run == 6) begin
               if (d) begin e_err = 1'b1; mode = 0; end else run = 0;
             end else begin
               e_vld = 1'b1; e_outb = d; run = d ? run + 1 : 0;
             end
           end else if (s0) mode = 3;
           else begin e_err = 1'b1; mode = 0; end
        3: if (s0) mode = 4; else begin e_err = 1'b1; mode = 0; end
        4: begin if (j) e_eop = 1'b1; else e_err = 1'b1; mode = 0; end
        default: mode = 0;
      endcase
      if (j || k) prev_k = k;
    end
    e_send = (mode >= 2);
  end

  // Per-scenario capture of what the DUT delivered.
  logic [31:0] cap_v;
  int cap_n, n_eop, n_err;

  always @(posedge clk) begin
    #2;
    if (armed) begin
      chk("sending", bus.sending, e_send);
      chk("outb_vld", bus.outb_vld, e_vld);
      chk("eop", bus.eop, e_eop);
      chk("err", bus.err, e_err);
      if (e_vld) chk("outb", bus.outb, e_outb);
      chk("eop_err_excl", bus.eop & bus.err, 0);
      if (bus.outb_vld) begin cap_v = {cap_v[30:0], bus.outb}; cap_n++; end
      if (bus.eop) n_eop++;
      if (bus.err) n_err++;
    end
  end

  task automatic line(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      case (s[i])
        "K":     {bus.dp, bus.dm} = 2'b01;
        "0":     {bus.dp, bus.dm} = 2'b00;
        "1":     {bus.dp, bus.dm} = 2'b11;
        default: {bus.dp, bus.dm} = 2'b10;
      endcase
    end
  endtask

  task automatic begin_scn();
    line("JJJJJJJJJJ");
    cap_v = 0; cap_n = 0; n_eop = 0; n_err = 0;
  endtask

  task automatic end_scn(input string nm, input string bits, input int eeop, input int eerr);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < bits.len(); i++) v = {v[30:0], bits[i] == "1"};
    line("JJJ");
    chk({nm, "_nbits"}, cap_n, bits.len());
    chk({nm, "_bits"}, cap_v, v);
    chk({nm, "_eops"}, n_eop, eeop);
    chk({nm, "_errs"}, n_err, eerr);
    chk({nm, "_idle"}, bus.sending, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.recving = 1'b1;
    {bus.dp, bus.dm} = 2'b10;
    @(posedge clk); #1 armed = 1'b1;
    @(posedge clk); #3;
    chk("rst_outb", bus.outb, 0);
    chk("rst_vld", bus.outb_vld, 0);
    chk("rst_sending", bus.sending, 0);
    chk("rst_eop", bus.eop, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;

    // Basic packet; sending must rise exactly after the 8th SYNC sample.
    begin_scn();
    line("KJKJKJK");
    @(posedge clk); #3 chk("sync7_sending", bus.sending, 0);
    line("K");
    @(posedge clk); #3 chk("sync8_sending", bus.sending, 1);
    line("KKJJ00J");
    end_scn("pkt_kkjj", "1101", 1, 0);

    begin_scn();
    line("KJKJKJKKKJJK00J");
    end_scn("pkt_kjjk", "1010", 1, 0);

    // Six 1s then a stuffed 0 (dropped) then a delivered 1.
    begin_scn();
    line("KJKJKJKKJJJJJJJKK00J");
    end_scn("stuff_ok", "01111111", 1, 0);

    // Seventh consecutive 1 is a stuffing violation.
    begin_scn();
    line("KJKJKJKKJJJJJJJJ");
    end_scn("stuff_err", "0111111", 0, 1);

    // Corrupted SYNC never opens a packet.
    begin_scn();
    line("KJKJKJKJKJKJKJKJKJ");
    end_scn("bad_sync", "", 0, 0);

    // Reset mid-packet after three payload bits, then a fresh packet.
    begin_scn();
    line("KJKJKJKKKJK");
    @(negedge clk); rst = 1'b1; {bus.dp, bus.dm} = 2'b01;
    @(posedge clk); #3;
    chk("mid_rst_outb", bus.outb, 0);
    chk("mid_rst_vld", bus.outb_vld, 0);
    chk("mid_rst_sending", bus.sending, 0);
    chk("mid_rst_eop", bus.eop, 0);
    chk("mid_rst_err", bus.err, 0);
    rst = 1'b0;
    chk("pre_rst_bits", cap_v, 32'b100);
    cap_v = 0; cap_n = 0;
    line("KJKJKJKKKJJK00J");
    end_scn("post_rst", "1010", 1, 0);

    // SE1 inside payload.
    begin_scn();
    line("KJKJKJKKKJ1");
    end_scn("se1", "10", 0, 1);

    // SE0 followed by K instead of a second SE0.
    begin_scn();
    line("KJKJKJKKKJ0K");
    end_scn("se0_k", "10", 0, 1);

    // Receive enable dropped mid-packet: silent return to idle.
    begin_scn();
    line("KJKJKJKKKJ");
    @(negedge clk); bus.recving = 1'b0; {bus.dp, bus.dm} = 2'b01;
    @(posedge clk); #3 chk("recv_off_sending", bus.sending, 0);
    line("K");
    @(negedge clk); bus.recving = 1'b1; {bus.dp, bus.dm} = 2'b10;
    end_scn("recv_off", "10", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
